// File: rtl/tipi_shreg_sequencer.sv
// Synchronises the RPi bit-bang strobes into clk and sequences 8-bit frames between
// the RPi and the RD/RC/TD/TC registers, with abort on regsel change or stall.
module tipi_shreg_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] rpi_regsel,
  input  logic       rpi_sdata_in,
  input  logic       rpi_le,
  input  logic       rpi_shclk,
  output logic       rpi_sdata_out,
  input  logic       ti_wr_data_stb,
  input  logic       ti_wr_ctrl_stb,
  input  logic [7:0] ti_wdata,
  output logic [7:0] rd_q,
  output logic [7:0] rc_q,
  output logic [7:0] td_q,
  output logic [7:0] tc_q,
  output logic       busy,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t      state, state_nxt;
  logic        frame_err_nxt;
  logic [4:0]  sync_q [SYNC_STAGES];
  logic        shclk_prev;
  logic [1:0]  frame_sel;
  logic [3:0]  count;
  logic [TW-1:0] tmo_cnt;
  logic [7:0]  in_shadow, out_shadow;

  // Every RPi line goes through the same chain depth so all fields of an edge line up.
  logic [1:0] s_regsel;
  logic       s_le, s_sdata, s_shclk;
  assign {s_regsel, s_le, s_sdata, s_shclk} = sync_q[SYNC_STAGES-1];

  logic edge_det, sel_bad, tmo_hit, act_latch, act_shift;
  logic [7:0] td_snap, tc_snap;

  assign edge_det  = s_shclk & ~shclk_prev;
  assign sel_bad   = (state == SHIFT) && edge_det && (s_regsel != frame_sel);
  assign tmo_hit   = (state == SHIFT) && !edge_det && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign act_latch = edge_det && s_le && !sel_bad;
  assign act_shift = edge_det && !s_le && !sel_bad;
  // A TI write landing on the same edge as a snapshot is bypassed into it.
  assign td_snap   = ti_wr_data_stb ? ti_wdata : td_q;
  assign tc_snap   = ti_wr_ctrl_stb ? ti_wdata : tc_q;
  assign busy      = (state == SHIFT);

  always_comb begin
    state_nxt     = state;
    frame_err_nxt = 1'b0;
    case (state)
      IDLE:  if (act_shift) state_nxt = SHIFT;
      SHIFT: begin
        if (sel_bad || tmo_hit) begin
          state_nxt     = IDLE;
          frame_err_nxt = 1'b1;
        end else if (act_latch) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      shclk_prev <= 1'b0;
      state      <= IDLE;
      frame_err  <= 1'b0;
    end else begin
      sync_q[0] <= {rpi_regsel, rpi_le, rpi_sdata_in, rpi_shclk};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      shclk_prev <= s_shclk;
      state      <= state_nxt;
      frame_err  <= frame_err_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q          <= '0;
      rc_q          <= '0;
      td_q          <= '0;
      tc_q          <= '0;
      in_shadow     <= '0;
      out_shadow    <= '0;
      rpi_sdata_out <= 1'b0;
      frame_sel     <= '0;
      count         <= '0;
      tmo_cnt       <= '0;
    end else begin
      if (ti_wr_data_stb) td_q <= ti_wdata;
      if (ti_wr_ctrl_stb) tc_q <= ti_wdata;

      if (edge_det || state == IDLE || tmo_hit) tmo_cnt <= '0;
      else                                      tmo_cnt <= tmo_cnt + 1'b1;

      if (state == IDLE && act_shift) frame_sel <= s_regsel;

      if (sel_bad || tmo_hit || act_latch) count <= '0;
      else if (act_shift && count != 4'd15) count <= count + 4'd1;

      if (act_latch) begin
        case (s_regsel)
          2'b00: rd_q <= in_shadow;
          2'b01: rc_q <= in_shadow;
          2'b10: begin out_shadow <= td_snap; rpi_sdata_out <= td_snap[7]; end
          default: begin out_shadow <= tc_snap; rpi_sdata_out <= tc_snap[7]; end
        endcase
      end else if (act_shift) begin
        if (!s_regsel[1]) begin
          in_shadow <= {in_shadow[6:0], s_sdata};
        end else begin
          out_shadow    <= {out_shadow[6:0], 1'b0};
          rpi_sdata_out <= out_shadow[6];
        end
      end
    end
  end

endmodule

// File: tb/tb_tipi_shreg_sequencer.sv
// Directed bench for tipi_shreg_sequencer: pin-history reference model checked every
// cycle, plus hand-computed expectations for each scenario.
module tb_tipi_shreg_sequencer;

  localparam int SYNC = 2;
  localparam int TMO  = 4096;

  logic       clk = 0;
  logic       rst_n = 1;
  logic [1:0] rpi_regsel = 0;
  logic       rpi_sdata_in = 0, rpi_le = 0, rpi_shclk = 0;
  logic       rpi_sdata_out;
  logic       ti_wr_data_stb = 0, ti_wr_ctrl_stb = 0;
  logic [7:0] ti_wdata = 0;
  logic [7:0] rd_q, rc_q, td_q, tc_q;
  logic       busy, frame_err;

  tipi_shreg_sequencer #(.SYNC_STAGES(SYNC), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .rpi_regsel(rpi_regsel), .rpi_sdata_in(rpi_sdata_in),
    .rpi_le(rpi_le), .rpi_shclk(rpi_shclk), .rpi_sdata_out(rpi_sdata_out),
    .ti_wr_data_stb(ti_wr_data_stb), .ti_wr_ctrl_stb(ti_wr_ctrl_stb), .ti_wdata(ti_wdata),
    .rd_q(rd_q), .rc_q(rc_q), .td_q(td_q), .tc_q(tc_q), .busy(busy), .frame_err(frame_err)
  );

  always #10 clk = ~clk;

  int n_vec = 0, n_bad = 0, cyc = 0, err_pulses = 0;
  logic chk_en = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (frame_err) err_pulses++;

  // Reference model: pin samples taken at each clk edge; an action happens when the
  // sample SYNC edges ago is high and the one before it low.
  typedef struct packed { logic [1:0] sel; logic le; logic d; logic sh; } pins_t;
  pins_t      h [0:SYNC];
  logic [7:0] m_rd = 0, m_rc = 0, m_td = 0, m_tc = 0, m_in = 0, m_out = 0;
  logic       m_busy = 0, m_err = 0, m_sdo = 0;
  logic [1:0] m_fsel = 0;
  int         m_cyc = 0, m_last = 0;

  always @(posedge clk or negedge rst_n) begin : model
    pins_t cur, now_p;
    logic ev, nerr;
    logic [7:0] ntd, ntc;
    if (!rst_n) begin
      for (int i = 0; i <= SYNC; i++) h[i] = '0;
      m_rd = 0; m_rc = 0; m_td = 0; m_tc = 0; m_in = 0; m_out = 0;
      m_busy = 0; m_err = 0; m_sdo = 0; m_fsel = 0; m_cyc = 0; m_last = 0;
    end else begin
      m_cyc++;
      cur   = {rpi_regsel, rpi_le, rpi_sdata_in, rpi_shclk};
      now_p = h[SYNC-1];
      ev    = now_p.sh && !h[SYNC].sh;
      nerr  = 0;
      ntd   = ti_wr_data_stb ? ti_wdata : m_td;
      ntc   = ti_wr_ctrl_stb ? ti_wdata : m_tc;
      if (ev) begin
        m_last = m_cyc;
        if (m_busy && now_p.sel != m_fsel) begin
          m_busy = 0; nerr = 1;
        end else if (now_p.le) begin
          case (now_p.sel)
            2'd0: m_rd = m_in;
            2'd1: m_rc = m_in;
            2'd2: begin m_out = ntd; m_sdo = ntd[7]; end
            default: begin m_out = ntc; m_sdo = ntc[7]; end
          endcase
          m_busy = 0;
        end else begin
          if (!m_busy) begin m_busy = 1; m_fsel = now_p.sel; end
          if (!now_p.sel[1]) m_in = {m_in[6:0], now_p.d};
          else begin m_sdo = m_out[6]; m_out = {m_out[6:0], 1'b0}; end
        end
      end else if (m_busy && (m_cyc - m_last) == TMO) begin
        m_busy = 0; nerr = 1;
      end
      m_td = ntd; m_tc = ntc; m_err = nerr;
      for (int i = SYNC; i > 0; i--) h[i] = h[i-1];
      h[0] = cur;
    end
  end

  always @(negedge clk) begin
    logic [34:0] act, exp_v;
    if (chk_en) begin
      act   = {rd_q, rc_q, td_q, tc_q, busy, frame_err, rpi_sdata_out};
      exp_v = {m_rd, m_rc, m_td, m_tc, m_busy, m_err, m_sdo};
      n_vec++;
      if (act !== exp_v) begin
        n_bad++;
        $display("FAIL model cyc=%0d: dut %h expected %h (rd rc td tc busy err sdo)", cyc, act, exp_v);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_vec++;
    if (act !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic rpi_edge(input logic [1:0] sel, input logic le, input logic d, output int t_set);
    @(negedge clk);
    rpi_regsel = sel; rpi_le = le; rpi_sdata_in = d; rpi_shclk = 1;
    t_set = cyc;
    repeat (SYNC + 2) @(negedge clk);
    rpi_shclk = 0;
    repeat (2) @(negedge clk);
  endtask

  task automatic ti_write(input logic dstb, input logic cstb, input logic [7:0] v);
    @(negedge clk);
    ti_wr_data_stb = dstb; ti_wr_ctrl_stb = cstb; ti_wdata = v;
    @(negedge clk);
    ti_wr_data_stb = 0; ti_wr_ctrl_stb = 0;
  endtask

  int t0, e0;
  logic [7:0] pat;
  logic [7:0] exp_seq;

  initial begin
    #3 rst_n = 0;
    repeat (3) @(negedge clk);
    rst_n = 1;
    chk_en = 1;
    chk("reset rd_q", rd_q, 0);
    chk("reset busy", busy, 0);
    chk("reset sdata_out", rpi_sdata_out, 0);
    chk("reset frame_err", frame_err, 0);

    // 1: RD in-frame 0xA5
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) rpi_edge(2'b00, 0, pat[i], t0);
    chk("t1 busy during frame", busy, 1);
    rpi_edge(2'b00, 1, 0, t0);
    chk("t1 rd_q", rd_q, 8'hA5);
    chk("t1 rc_q", rc_q, 8'h00);
    chk("t1 busy after latch", busy, 0);

    // simultaneous data + ctrl strobes
    ti_write(1, 1, 8'h66);
    chk("dual stb td_q", td_q, 8'h66);
    chk("dual stb tc_q", tc_q, 8'h66);

    // 2: TD out-frame 0x3C, with a TI write mid-frame
    ti_write(1, 0, 8'h3C);
    rpi_edge(2'b10, 1, 0, t0);
    exp_seq = 8'b0011_1100;
    chk("t2 bit0", rpi_sdata_out, exp_seq[7]);
    for (int i = 6; i >= 0; i--) begin
      rpi_edge(2'b10, 0, 0, t0);
      chk($sformatf("t2 bit%0d", 7 - i), rpi_sdata_out, exp_seq[i]);
      if (i == 4) ti_write(1, 0, 8'hFF);
    end
    chk("t2 td_q after write", td_q, 8'hFF);
    rpi_edge(2'b10, 1, 0, t0);

    // 3: ctrl strobe on the same edge as the TC snapshot
    @(negedge clk);
    rpi_regsel = 2'b11; rpi_le = 1; rpi_shclk = 1;
    repeat (SYNC) @(negedge clk);
    ti_wr_ctrl_stb = 1; ti_wdata = 8'h81;
    @(negedge clk);
    ti_wr_ctrl_stb = 0;
    repeat (2) @(negedge clk);
    rpi_shclk = 0;
    repeat (2) @(negedge clk);
    chk("t3 tc_q", tc_q, 8'h81);
    chk("t3 bit0", rpi_sdata_out, 1);
    for (int i = 1; i <= 7; i++) begin
      rpi_edge(2'b11, 0, 0, t0);
      chk($sformatf("t3 bit%0d", i), rpi_sdata_out, (i == 7) ? 1 : 0);
    end
    rpi_edge(2'b11, 1, 0, t0);

    // 4: regsel change mid-frame aborts; the offending edge is ignored
    for (int i = 0; i < 3; i++) rpi_edge(2'b01, 0, 1, t0);
    e0 = err_pulses;
    rpi_edge(2'b00, 0, 0, t0);
    chk("t4 frame_err pulses", err_pulses - e0, 1);
    chk("t4 busy", busy, 0);
    chk("t4 rc_q", rc_q, 8'h00);
    rpi_edge(2'b00, 1, 0, t0);
    chk("t4 rd_q from kept shadow", rd_q, 8'h2F);

    // 5: stall after two bits times out
    rpi_edge(2'b00, 0, 0, t0);
    rpi_edge(2'b00, 0, 1, t0);
    for (int i = 0; i < TMO + 100 && !frame_err; i++) @(negedge clk);
    chk("t5 frame_err seen", frame_err, 1);
    chk("t5 timeout latency", cyc - t0, SYNC + 1 + TMO);
    @(negedge clk);
    chk("t5 frame_err one cycle", frame_err, 0);
    chk("t5 rd_q", rd_q, 8'h2F);

    // 6: async reset mid-frame, then a clean 0x5A frame
    pat = 8'h5A;
    for (int i = 7; i >= 3; i--) rpi_edge(2'b00, 0, pat[i], t0);
    #2 rst_n = 0;
    #1;
    chk("t6 reset busy", busy, 0);
    chk("t6 reset td_q", td_q, 0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    rpi_regsel = 2'b00; rpi_le = 0; rpi_sdata_in = pat[7]; rpi_shclk = 1;
    t0 = cyc;
    for (int i = 0; i < 20 && !busy; i++) @(negedge clk);
    chk("t6 pin-to-action", cyc - t0, SYNC + 1);
    repeat (2) @(negedge clk);
    rpi_shclk = 0;
    repeat (2) @(negedge clk);
    for (int i = 6; i >= 0; i--) rpi_edge(2'b00, 0, pat[i], t0);
    rpi_edge(2'b00, 1, 0, t0);
    chk("t6 rd_q", rd_q, 8'h5A);

    repeat (4) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: bench did not complete, got timeout expected finish");
    $fatal(1);
  end

endmodule
